// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduler slice.
// Holds the scheduler state encoding, the channel-count ceiling, default timing
// constants and a helper that sizes cycle counters from a cycle budget.
package ws2812_pkg;

  typedef enum logic [1:0] {
    STA_IDLE  = 2'd0,
    STA_SWAP  = 2'd1,
    STA_START = 2'd2,
    STA_RUN   = 2'd3
  } sta_t;

  localparam int MAX_CH             = 8;
  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_REFRESH_CYCLES = 2_000_000;  // 40 ms at 50 MHz
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  // A counter that must reach cycles-1 needs $clog2(cycles) bits; never allow zero width.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ws2812_done_collect.sv
// Completion collector: latches the channel enable mask at frame start and
// accumulates per-channel done pulses until every enabled channel has reported.
// Ports: load (latch mask / clear seen), accum (collect dones), chan_en, chan_done,
//        mask (latched enables), all_done (combinational: seen|new covers mask, while accum).
module ws2812_done_collect
  import ws2812_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              load,
  input  logic              accum,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic [NUM_CH-1:0] chan_done,
  output logic [NUM_CH-1:0] mask,
  output logic              all_done
);

  logic [NUM_CH-1:0] done_seen;
  logic [NUM_CH-1:0] done_new;

  // Dones on channels outside the latched mask are dropped here.
  assign done_new = chan_done & mask;

  // Including this cycle's pulses lets the scheduler leave RUN on the last done.
  assign all_done = accum && ((done_seen | done_new) == mask);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mask      <= '0;
      done_seen <= '0;
    end else if (load) begin
      mask      <= chan_en;
      done_seen <= '0;
    end else if (accum) begin
      // OR accumulation makes repeated dones on one channel harmless.
      done_seen <= done_seen | done_new;
    end
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler for NUM_CH parallel WS2812 channels sharing a ping-pong pixel RAM.
// Swaps banks on host commit while idle, starts enabled channels, waits for all
// completions under a timeout, and optionally re-sends the front bank on a refresh timer.
// Ports: commit_in / auto_refresh_en / chan_en_in / chan_done_in from host and channels;
//        frame_rdy_out start pulses, bank_rd/wr_sel_out bank selects, commit_ack_out,
//        busy_out, timeout_err_out (sticky), overrun_out (commit while one is pending).
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              commit_in,
  input  logic              auto_refresh_en,
  input  logic [NUM_CH-1:0] chan_en_in,
  input  logic [NUM_CH-1:0] chan_done_in,
  output logic [NUM_CH-1:0] frame_rdy_out,
  output logic              bank_wr_sel_out,
  output logic              bank_rd_sel_out,
  output logic              commit_ack_out,
  output logic              busy_out,
  output logic              timeout_err_out,
  output logic              overrun_out
);

  localparam int RW = cnt_width(REFRESH_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  sta_t              state_q;
  sta_t              state_nxt;
  logic              pending_q;
  logic [RW-1:0]     refresh_cnt;
  logic [TW-1:0]     run_cnt;
  logic [NUM_CH-1:0] mask;
  logic              all_done;

  logic              timeout_hit;
  logic              ack_nxt;
  logic              busy_nxt;
  logic              overrun_nxt;
  logic [NUM_CH-1:0] frame_nxt;

  ws2812_done_collect #(
    .NUM_CH (NUM_CH)
  ) u_done_collect (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .load      (state_q == STA_START),
    .accum     (state_q == STA_RUN),
    .chan_en   (chan_en_in),
    .chan_done (chan_done_in),
    .mask      (mask),
    .all_done  (all_done)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_nxt   = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      STA_IDLE: begin
        // A commit arriving this cycle is honoured immediately so the swap
        // follows one cycle after the pulse; the pending flag covers commits
        // that arrived while the display was busy.
        if (pending_q || commit_in) begin
          state_nxt = STA_SWAP;
        end else if (auto_refresh_en && (refresh_cnt == REFRESH_LAST)) begin
          state_nxt = STA_START;
        end
      end
      STA_SWAP: begin
        state_nxt = STA_START;
      end
      STA_START: begin
        state_nxt = (chan_en_in == '0) ? STA_IDLE : STA_RUN;
      end
      STA_RUN: begin
        if (all_done) begin
          state_nxt = STA_IDLE;
        end else if (run_cnt == TIMEOUT_LAST) begin
          state_nxt   = STA_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: begin
        state_nxt = STA_IDLE;
      end
    endcase

    ack_nxt     = (state_nxt == STA_SWAP);
    busy_nxt    = (state_nxt != STA_IDLE);
    frame_nxt   = (state_q == STA_START) ? chan_en_in : '0;
    // In SWAP the old commit is being consumed, so a new one there is not an overrun.
    overrun_nxt = commit_in && pending_q && (state_q != STA_SWAP);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= STA_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Pending commit: cleared by SWAP unless a fresh commit lands in the same cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= commit_in || (pending_q && (state_q != STA_SWAP));
    end
  end

  // Refresh timer: runs only while idle, restarts whenever a frame finishes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      refresh_cnt <= '0;
    end else if ((state_q == STA_RUN) && (state_nxt == STA_IDLE)) begin
      refresh_cnt <= '0;
    end else if ((state_q == STA_IDLE) && (refresh_cnt != REFRESH_LAST)) begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Timeout counter: zero on the first RUN cycle, leaves RUN before it could wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_cnt <= '0;
    end else if (state_q == STA_START) begin
      run_cnt <= '0;
    end else if ((state_q == STA_RUN) && (run_cnt != TIMEOUT_LAST)) begin
      run_cnt <= run_cnt + TW'(1);
    end
  end

  // Bank selects flip together at the end of SWAP, never during a frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bank_rd_sel_out <= 1'b0;
      bank_wr_sel_out <= 1'b1;
    end else if (state_q == STA_SWAP) begin
      bank_rd_sel_out <= ~bank_rd_sel_out;
      bank_wr_sel_out <= ~bank_wr_sel_out;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_rdy_out   <= '0;
      commit_ack_out  <= 1'b0;
      busy_out        <= 1'b0;
      overrun_out     <= 1'b0;
      timeout_err_out <= 1'b0;
    end else begin
      frame_rdy_out   <= frame_nxt;
      commit_ack_out  <= ack_nxt;
      busy_out        <= busy_nxt;
      overrun_out     <= overrun_nxt;
      if (timeout_hit) begin
        timeout_err_out <= 1'b1;
      end
    end
  end

endmodule
